// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack sequencer: widths, operation codes, FSM state
// encoding and the decode from an accepted op_code to its first working state.
package stack_ctrl_pkg;

  localparam int DW_DEF     = 8;
  localparam int FLAG_W_DEF = 4;
  localparam int SP_IDX     = 3;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_INT  = 3'd4,
    OP_RTI  = 3'd5
  } op_code_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_POP_RD,
    S_POP_WB,
    S_CALL,
    S_RET_RD,
    S_RET_WB,
    S_INT_PC,
    S_INT_FL,
    S_RTI_FL,
    S_RTI_PC,
    S_RTI_WB,
    S_BAD
  } state_e;

  function automatic state_e first_state(input logic [2:0] code);
    state_e s;
    case (code)
      OP_PUSH: s = S_PUSH;
      OP_POP:  s = S_POP_RD;
      OP_CALL: s = S_CALL;
      OP_RET:  s = S_RET_RD;
      OP_INT:  s = S_INT_PC;
      OP_RTI:  s = S_RTI_FL;
      default: s = S_BAD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Bundle of every non-clock signal between the stack sequencer and its neighbours
// (decode stage, register file, data memory, PC/CCR). slave = the sequencer.
interface stack_ctrl_if #(
  parameter int DW     = 8,
  parameter int FLAG_W = 4
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [1:0]        op_reg;
  logic [DW-1:0]     op_pc;
  logic [DW-1:0]     op_target;
  logic [FLAG_W-1:0] flags_in;
  logic [DW-1:0]     sp_in;
  logic [1:0]        rf_rd_addr;
  logic [DW-1:0]     rf_rd_data;
  logic              rf_we;
  logic [1:0]        rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;
  logic              sp_inc;
  logic              sp_dec;
  logic [DW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DW-1:0]     mem_rdata;
  logic              pc_load;
  logic [DW-1:0]     pc_out;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_out;
  logic              done;
  logic              stk_err;

  modport master (
    output op_valid, op_code, op_reg, op_pc, op_target, flags_in,
    output sp_in, rf_rd_data, mem_rdata,
    input  op_ready, rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data, sp_inc, sp_dec,
    input  mem_addr, mem_wdata, mem_we, mem_re, pc_load, pc_out,
    input  flags_load, flags_out, done, stk_err
  );

  modport slave (
    input  op_valid, op_code, op_reg, op_pc, op_target, flags_in,
    input  sp_in, rf_rd_data, mem_rdata,
    output op_ready, rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data, sp_inc, sp_dec,
    output mem_addr, mem_wdata, mem_we, mem_re, pc_load, pc_out,
    output flags_load, flags_out, done, stk_err
  );

endinterface

// File: rtl/stack_ctrl.sv
// Multi-cycle sequencer for PUSH/POP/CALL/RET/INT/RTI. One FSM; every output is a
// combinational decode of the current state, the latched request and SP/memory data.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input logic          clk,
  input logic          rst,
  stack_ctrl_if.slave  bus
);

  state_e            state_q,  state_d;
  logic [1:0]        reg_q,    reg_d;
  logic [DW-1:0]     pc_q,     pc_d;
  logic [DW-1:0]     target_q, target_d;
  logic [FLAG_W-1:0] flags_q,  flags_d;

  logic [DW-1:0] sp_plus1;
  logic          sp_at_min;
  logic          sp_at_max;

  // Pops address the slot above SP; the register file bumps SP at the same edge.
  assign sp_plus1  = bus.sp_in + DW'(1);
  assign sp_at_min = (bus.sp_in == '0);
  assign sp_at_max = &bus.sp_in;

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    pc_d     = pc_q;
    target_d = target_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          state_d  = first_state(bus.op_code);
          reg_d    = bus.op_reg;
          pc_d     = bus.op_pc;
          target_d = bus.op_target;
          flags_d  = bus.flags_in;
        end
      end
      S_POP_RD: state_d = S_POP_WB;
      S_RET_RD: state_d = S_RET_WB;
      S_INT_PC: state_d = S_INT_FL;
      S_RTI_FL: state_d = S_RTI_PC;
      S_RTI_PC: state_d = S_RTI_WB;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; the
  // reset branch sits inside the clocked block, making it synchronous.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      reg_q    <= '0;
      pc_q     <= '0;
      target_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      reg_q    <= reg_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      flags_q  <= flags_d;
    end
  end

  // NOTE: every output gets a default before the case, so no state can infer a latch.
  always_comb begin
    bus.op_ready   = 1'b0;
    bus.rf_rd_addr = '0;
    bus.rf_we      = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    bus.sp_inc     = 1'b0;
    bus.sp_dec     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.pc_out     = '0;
    bus.flags_load = 1'b0;
    bus.flags_out  = '0;
    bus.done       = 1'b0;
    bus.stk_err    = 1'b0;
    case (state_q)
      S_IDLE: bus.op_ready = 1'b1;
      S_PUSH: begin
        bus.rf_rd_addr = reg_q;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = bus.sp_in;
        bus.mem_wdata  = bus.rf_rd_data;
        bus.sp_dec     = 1'b1;
        bus.stk_err    = sp_at_min;
        bus.done       = 1'b1;
      end
      S_POP_RD, S_RET_RD, S_RTI_FL: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = sp_plus1;
        bus.sp_inc   = 1'b1;
        bus.stk_err  = sp_at_max;
      end
      S_POP_WB: begin
        bus.rf_we      = 1'b1;
        bus.rf_wr_addr = reg_q;
        bus.rf_wr_data = bus.mem_rdata;
        bus.done       = 1'b1;
      end
      S_CALL: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.sp_in;
        bus.mem_wdata = pc_q;
        bus.sp_dec    = 1'b1;
        bus.stk_err   = sp_at_min;
        bus.pc_load   = 1'b1;
        bus.pc_out    = target_q;
        bus.done      = 1'b1;
      end
      S_RET_WB, S_RTI_WB: begin
        bus.pc_load = 1'b1;
        bus.pc_out  = bus.mem_rdata;
        bus.done    = 1'b1;
      end
      S_INT_PC: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.sp_in;
        bus.mem_wdata = pc_q;
        bus.sp_dec    = 1'b1;
        bus.stk_err   = sp_at_min;
      end
      S_INT_FL: begin
        // sp_in already reflects the decrement issued for the PC push.
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.sp_in;
        bus.mem_wdata = {{(DW-FLAG_W){1'b0}}, flags_q};
        bus.sp_dec    = 1'b1;
        bus.stk_err   = sp_at_min;
        bus.pc_load   = 1'b1;
        bus.pc_out    = target_q;
        bus.done      = 1'b1;
      end
      S_RTI_PC: begin
        bus.flags_load = 1'b1;
        bus.flags_out  = bus.mem_rdata[FLAG_W-1:0];
        bus.mem_re     = 1'b1;
        bus.mem_addr   = sp_plus1;
        bus.sp_inc     = 1'b1;
        bus.stk_err    = sp_at_max;
      end
      S_BAD: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench: behavioural register file / memory around stack_ctrl, a
// table of spec-derived vectors, a reset-abort sequence and randomized ops vs a model.
module tb_stack_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DW(8), .FLAG_W(4)) bus ();

  stack_ctrl #(.DW(8), .FLAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Environment: register file (R3 = SP), synchronous-read memory, PC and CCR.
  logic [7:0] env_rf  [4];
  logic [7:0] env_mem [256];
  logic [7:0] env_rdata;
  logic [7:0] env_pc;
  logic [3:0] env_flags;
  logic       env_init;
  logic       poke_en;
  logic [1:0] poke_idx;
  logic [7:0] poke_val;

  assign bus.sp_in      = env_rf[3];
  assign bus.rf_rd_data = env_rf[bus.rf_rd_addr];
  assign bus.mem_rdata  = env_rdata;

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h3C;
      for (int i = 0; i < 3; i++) env_rf[i] <= 8'h00;
      env_rf[3] <= 8'hFF;
      env_pc    <= 8'h00;
      env_flags <= 4'h0;
      env_rdata <= 8'h00;
    end else begin
      if (poke_en)     env_rf[poke_idx] <= poke_val;
      if (bus.rf_we)   env_rf[bus.rf_wr_addr] <= bus.rf_wr_data;
      if (bus.sp_inc)  env_rf[3] <= env_rf[3] + 8'd1;
      if (bus.sp_dec)  env_rf[3] <= env_rf[3] - 8'd1;
      if (bus.mem_we)  env_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re)  env_rdata <= env_mem[bus.mem_addr];
      if (bus.pc_load) env_pc <= bus.pc_out;
      if (bus.flags_load) env_flags <= bus.flags_out;
    end
  end

  // Reference model state: the stack as plain arrays with wrap-around SP arithmetic.
  logic [7:0] m_rf  [4];
  logic [7:0] m_mem [256];
  logic [7:0] m_pc;
  logic [3:0] m_flags;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic m_push(input logic [7:0] v, inout int errs);
    if (m_rf[3] == 8'h00) errs++;
    m_mem[m_rf[3]] = v;
    m_rf[3] = m_rf[3] - 8'd1;
  endtask

  task automatic m_pop(output logic [7:0] v, inout int errs);
    if (m_rf[3] == 8'hFF) errs++;
    m_rf[3] = m_rf[3] + 8'd1;
    v = m_mem[m_rf[3]];
  endtask

  task automatic model_op(input logic [2:0] code, input logic [1:0] r, input logic [7:0] pc,
                          input logic [7:0] tgt, input logic [3:0] fl,
                          output int lat, output int errs, output int pcc, output int flc);
    logic [7:0] v;
    errs = 0; pcc = 0; flc = 0; lat = 1;
    case (code)
      3'd0: m_push(m_rf[r], errs);
      3'd1: begin m_pop(v, errs); m_rf[r] = v; lat = 2; end
      3'd2: begin m_push(pc, errs); m_pc = tgt; pcc = 1; end
      3'd3: begin m_pop(v, errs); m_pc = v; lat = 2; pcc = 2; end
      3'd4: begin m_push(pc, errs); m_push({4'h0, fl}, errs); m_pc = tgt; lat = 2; pcc = 2; end
      3'd5: begin
        m_pop(v, errs); m_flags = v[3:0];
        m_pop(v, errs); m_pc = v;
        lat = 3; pcc = 3; flc = 2;
      end
      default: ;
    endcase
  endtask

  // Issues one operation and observes it cycle by cycle until done (bounded).
  task automatic run_op(input logic [2:0] code, input logic [1:0] r, input logic [7:0] pc,
                        input logic [7:0] tgt, input logic [3:0] fl,
                        output int lat, output int errs, output int acts, output int clash,
                        output int pcc, output int flc);
    int waitc;
    lat = 0; errs = 0; acts = 0; clash = 0; pcc = 0; flc = 0; waitc = 0;
    while (!bus.op_ready && waitc < 20) begin @(negedge clk); waitc++; end
    check("ready_before_op", bus.op_ready, 1);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_reg = r;
    bus.op_pc = pc; bus.op_target = tgt; bus.flags_in = fl;
    @(negedge clk);
    bus.op_valid  = 1'b0;
    bus.op_code   = 3'($urandom); bus.op_reg = 2'($urandom);
    bus.op_pc     = 8'($urandom); bus.op_target = 8'($urandom);
    bus.flags_in  = 4'($urandom);
    for (int c = 1; c <= 8; c++) begin
      if (bus.stk_err) errs++;
      if (bus.rf_we || bus.sp_inc || bus.sp_dec || bus.mem_we || bus.mem_re ||
          bus.pc_load || bus.flags_load) acts++;
      if (bus.rf_we && (bus.sp_inc || bus.sp_dec)) clash++;
      if (bus.pc_load) pcc = c;
      if (bus.flags_load) flc = c;
      if (bus.done) begin lat = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    check("ready_after_done", bus.op_ready, 1);
  endtask

  task automatic compare_state(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_rf%0d", tag, i), env_rf[i], m_rf[i]);
    check({tag, "_pc"}, env_pc, m_pc);
    check({tag, "_flags"}, env_flags, m_flags);
    for (int i = 0; i < 256; i++) if (env_mem[i] !== m_mem[i]) mism++;
    check({tag, "_mem_mismatches"}, mism, 0);
  endtask

  task automatic poke(input logic [1:0] idx, input logic [7:0] v);
    poke_en = 1'b1; poke_idx = idx; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
    m_rf[idx] = v;
  endtask

  // Full op: model prediction, DUT run, and all generic comparisons.
  task automatic do_op(input string tag, input logic [2:0] code, input logic [1:0] r,
                       input logic [7:0] pc, input logic [7:0] tgt, input logic [3:0] fl,
                       output int lat, output int errs, output int pcc, output int flc);
    int e_lat, e_err, e_pcc, e_flc, acts, clash;
    model_op(code, r, pc, tgt, fl, e_lat, e_err, e_pcc, e_flc);
    run_op(code, r, pc, tgt, fl, lat, errs, acts, clash, pcc, flc);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_stk_err_pulses"}, errs, e_err);
    check({tag, "_rf_we_sp_clash"}, clash, 0);
    check({tag, "_active_cycles"}, acts, (code >= 3'd6) ? 0 : e_lat);
    check({tag, "_pc_load_cycle"}, pcc, e_pcc);
    check({tag, "_flags_load_cycle"}, flc, e_flc);
    compare_state(tag);
  endtask

  typedef struct {
    bit         preset;
    logic [7:0] psp;
    logic [2:0] code;
    logic [1:0] r;
    logic [7:0] pc;
    logic [7:0] tgt;
    logic [3:0] fl;
    int         lat;
    int         err;
    logic [7:0] sp;
    logic [7:0] pcx;
    logic [3:0] flx;
    logic [1:0] chk_r;
    logic [7:0] chk_v;
    int         pcc;
    int         flc;
  } vec_t;

  function automatic vec_t mk(bit preset, logic [7:0] psp, logic [2:0] code, logic [1:0] r,
                              logic [7:0] pc, logic [7:0] tgt, logic [3:0] fl, int lat, int err,
                              logic [7:0] sp, logic [7:0] pcx, logic [3:0] flx,
                              logic [1:0] chk_r, logic [7:0] chk_v, int pcc, int flc);
    vec_t v;
    v.preset = preset; v.psp = psp; v.code = code; v.r = r; v.pc = pc; v.tgt = tgt; v.fl = fl;
    v.lat = lat; v.err = err; v.sp = sp; v.pcx = pcx; v.flx = flx;
    v.chk_r = chk_r; v.chk_v = chk_v; v.pcc = pcc; v.flc = flc;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, errs, pcc, flc;
    logic [48:0] outs;

    // Expected values below come straight from the stack rules with memory M[i] = i ^ 0x3C.
    vecs[0]  = mk(0, 8'h00, 3'd0, 2'd1, 8'h00, 8'h00, 4'h0, 1, 0, 8'hFE, 8'h00, 4'h0, 2'd1, 8'h5A, 0, 0);
    vecs[1]  = mk(0, 8'h00, 3'd1, 2'd2, 8'h00, 8'h00, 4'h0, 2, 0, 8'hFF, 8'h00, 4'h0, 2'd2, 8'h5A, 0, 0);
    vecs[2]  = mk(0, 8'h00, 3'd2, 2'd0, 8'h21, 8'h80, 4'h0, 1, 0, 8'hFE, 8'h80, 4'h0, 2'd2, 8'h5A, 1, 0);
    vecs[3]  = mk(0, 8'h00, 3'd3, 2'd0, 8'h00, 8'h00, 4'h0, 2, 0, 8'hFF, 8'h21, 4'h0, 2'd2, 8'h5A, 2, 0);
    vecs[4]  = mk(0, 8'h00, 3'd4, 2'd0, 8'h40, 8'h10, 4'hA, 2, 0, 8'hFD, 8'h10, 4'h0, 2'd2, 8'h5A, 2, 0);
    vecs[5]  = mk(0, 8'h00, 3'd5, 2'd0, 8'h00, 8'h00, 4'h0, 3, 0, 8'hFF, 8'h40, 4'hA, 2'd2, 8'h5A, 3, 2);
    vecs[6]  = mk(1, 8'h00, 3'd0, 2'd1, 8'h00, 8'h00, 4'h0, 1, 1, 8'hFF, 8'h40, 4'hA, 2'd1, 8'h5A, 0, 0);
    vecs[7]  = mk(0, 8'h00, 3'd1, 2'd0, 8'h00, 8'h00, 4'h0, 2, 1, 8'h00, 8'h40, 4'hA, 2'd0, 8'h5A, 0, 0);
    vecs[8]  = mk(0, 8'h00, 3'd7, 2'd3, 8'h55, 8'h66, 4'hF, 1, 0, 8'h00, 8'h40, 4'hA, 2'd0, 8'h5A, 0, 0);
    vecs[9]  = mk(0, 8'h00, 3'd6, 2'd1, 8'h12, 8'h34, 4'h5, 1, 0, 8'h00, 8'h40, 4'hA, 2'd0, 8'h5A, 0, 0);
    vecs[10] = mk(1, 8'h40, 3'd0, 2'd3, 8'h00, 8'h00, 4'h0, 1, 0, 8'h3F, 8'h40, 4'hA, 2'd3, 8'h3F, 0, 0);
    vecs[11] = mk(1, 8'h20, 3'd1, 2'd3, 8'h00, 8'h00, 4'h0, 2, 0, 8'h1D, 8'h40, 4'hA, 2'd3, 8'h1D, 0, 0);

    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_reg = '0;
    bus.op_pc = '0; bus.op_target = '0; bus.flags_in = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    env_init = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
    for (int i = 0; i < 3; i++) m_rf[i] = 8'h00;
    m_rf[3] = 8'hFF; m_pc = 8'h00; m_flags = 4'h0;
    repeat (3) @(negedge clk);
    env_init = 1'b0;

    outs = {bus.rf_we, bus.sp_inc, bus.sp_dec, bus.mem_we, bus.mem_re, bus.pc_load,
            bus.flags_load, bus.done, bus.stk_err, bus.rf_rd_addr, bus.rf_wr_addr,
            bus.rf_wr_data, bus.mem_addr, bus.mem_wdata, bus.pc_out, bus.flags_out};
    check("reset_op_ready", bus.op_ready, 1);
    check("reset_outputs_zero", outs, 0);
    rst = 1'b1;
    @(negedge clk);
    poke(2'd1, 8'h5A);

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].preset) poke(2'd3, vecs[i].psp);
      do_op(tag, vecs[i].code, vecs[i].r, vecs[i].pc, vecs[i].tgt, vecs[i].fl, lat, errs, pcc, flc);
      check({tag, "_tbl_latency"}, lat, vecs[i].lat);
      check({tag, "_tbl_stk_err"}, errs, vecs[i].err);
      check({tag, "_tbl_sp"}, env_rf[3], vecs[i].sp);
      check({tag, "_tbl_pc"}, env_pc, vecs[i].pcx);
      check({tag, "_tbl_flags"}, env_flags, vecs[i].flx);
      check({tag, "_tbl_reg"}, env_rf[vecs[i].chk_r], vecs[i].chk_v);
      check({tag, "_tbl_pc_cycle"}, pcc, vecs[i].pcc);
      check({tag, "_tbl_flags_cycle"}, flc, vecs[i].flc);
      if (i == 4) begin
        check("int_saved_pc", env_mem[8'hFF], 8'h40);
        check("int_saved_flags", env_mem[8'hFE], 8'h0A);
      end
    end

    // Reset while the first RTI pop is in flight: the issued sp_inc still lands.
    while (!bus.op_ready) @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("abort_rti_fl_sp_inc", bus.sp_inc, 1);
    rst = 1'b0;
    m_rf[3] = m_rf[3] + 8'd1;
    @(negedge clk);
    outs = {bus.rf_we, bus.sp_inc, bus.sp_dec, bus.mem_we, bus.mem_re, bus.pc_load,
            bus.flags_load, bus.done, bus.stk_err, bus.rf_rd_addr, bus.rf_wr_addr,
            bus.rf_wr_data, bus.mem_addr, bus.mem_wdata, bus.pc_out, bus.flags_out};
    check("abort_op_ready", bus.op_ready, 1);
    check("abort_outputs_zero", outs, 0);
    rst = 1'b1;
    @(negedge clk);
    compare_state("abort");

    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) poke(2'd3, 8'h00);
      else if (sel == 1) poke(2'd3, 8'hFF);
      else if (sel == 2) poke(2'd3, 8'($urandom_range(0, 2)));
      else if (sel == 3) poke(2'($urandom_range(0, 2)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_op($sformatf("rnd%0d", n), 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
            4'($urandom), lat, errs, pcc, flc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Multi-cycle sequencer for all stack traffic in the 8-bit core: PUSH, POP, CALL, RET, INT and RTI.
- Accepts one stack operation per valid/ready handshake from the decode stage.
- Drives the register file's write port, rb read address and sp_inc/sp_dec strobes, the data-memory port, and the PC/flags load strobes.
- Stack grows downward, post-decrement push (M[SP] <= x; SP--), pre-increment pop (SP++; x <= M[SP]); SP = R3, reset value 0xFF owned by the register file.

Parameters:
DW, 8, data/address width
FLAG_W, 4, CCR width saved by INT / restored by RTI
SP_IDX, 3, register index of SP

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
op_valid  in  1  operation request
op_ready  out  1  high only in IDLE
op_code  in  3  0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6-7 illegal
op_reg  in  2  source (PUSH) / destination (POP) register
op_pc  in  DW  return address to save (CALL/INT)
op_target  in  DW  call target / interrupt vector
flags_in  in  FLAG_W  current CCR (INT)
sp_in  in  DW  raw R3 value (never the incremented read-port view)
rf_rd_addr  out  2  register file rb address
rf_rd_data  in  DW  register file rb data
rf_we, rf_wr_addr, rf_wr_data  out  1/2/DW  register file write port
sp_inc, sp_dec  out  1  SP strobes to register file
mem_addr  out  DW ; mem_wdata out DW ; mem_we out 1 ; mem_re out 1
mem_rdata  in  DW  data valid the cycle after mem_re (synchronous read)
pc_load  out  1 ; pc_out  out  DW
flags_load  out  1 ; flags_out  out  FLAG_W
done  out  1  one-cycle pulse in the final cycle of every operation
stk_err  out  1  one-cycle pulse on SP wrap (push at SP=0x00, pop at SP=0xFF)

Behaviour:
- Reset (rst=0 at edge): state IDLE, latched fields cleared, all outputs 0 except op_ready=1.
- Reset mid-operation aborts immediately; strobes already issued are not undone.
- Handshake: accept when op_valid && op_ready (cycle T); op_code/op_reg/op_pc/op_target/flags_in latched at T. Inputs ignored while busy.
- All outputs are combinational decodes of the registered state plus latched fields; unlisted strobes are 0.
- sp_in reflects SP updates from the prior cycle, because the register file updates SP at the edge.
- rf_we and sp_inc/sp_dec are never high in the same cycle.
- Operation sequences:
  - PUSH (T+1, done): rf_rd_addr=reg, mem_we, mem_addr=sp_in, mem_wdata=rf_rd_data, sp_dec.
  - POP (T+1): mem_re, mem_addr=sp_in+1 (mod 256), sp_inc.
  - POP (T+2, done): rf_we, rf_wr_addr=reg, rf_wr_data=mem_rdata.
  - CALL (T+1, done): mem_we M[sp_in]<=pc, sp_dec, pc_load, pc_out=target.
  - RET (T+1): mem_re at sp_in+1, sp_inc.
  - RET (T+2, done): pc_load, pc_out=mem_rdata.
  - INT (T+1): push pc, sp_dec.
  - INT (T+2, done): push zero-extended flags at the new sp_in, sp_dec, pc_load=target.
  - RTI (T+1): pop read, sp_inc.
  - RTI (T+2): flags_load, flags_out=mem_rdata[FLAG_W-1:0]; second pop read, sp_inc.
  - RTI (T+3, done): pc_load, pc_out=mem_rdata.
  - Illegal opcode (T+1, done): no other strobes.
- States: IDLE, PUSH, POP_RD, POP_WB, CALL, RET_RD, RET_WB, INT_PC, INT_FL, RTI_FL, RTI_PC, RTI_WB, BAD. Every final state returns to IDLE, so op_ready rises at the cycle after done.
- Wrap: address arithmetic is modulo 2^DW; SP wraps silently. stk_err pulses in the cycle issuing the wrapping sp_dec/sp_inc, and the operation still completes.
- PUSH R3 stores the pre-decrement SP. POP R3 leaves R3 = popped value, because the write happens at T+2 after the increment.

Decomposition:
- Shared package: op_code constants, FSM state encoding, DW/FLAG_W/SP_IDX defaults.
- No sub-module; single FSM with combinational output decode.

Test Plan:
1. Reset with SP=0xFF, R1=0x5A; PUSH R1 -> M[0xFF]=0x5A, SP=0xFE, done at T+1, op_ready back at T+2.
2. Then POP R2 -> mem_re addr 0xFF at T+1 with sp_inc; R2=0x5A at T+2; SP=0xFF.
3. CALL pc=0x21 target=0x80 at SP=0xFF -> M[0xFF]=0x21, pc_out=0x80, SP=0xFE; then RET -> pc_out=0x21 at T+2, SP=0xFF.
4. INT pc=0x40 flags=0xA vector=0x10 -> M[0xFF]=0x40, M[0xFE]=0x0A, SP=0xFD, pc_out=0x10. Then RTI -> flags_out=0xA at T+2, pc_out=0x40 at T+3, SP=0xFF.
5. PUSH at SP=0x00 -> M[0x00] written, SP=0xFF, stk_err pulse. POP at SP=0xFF -> reads M[0x00], SP=0x00, stk_err pulse.
6. Assert rst=0 during RTI_FL -> next cycle IDLE, all strobes 0, op_ready=1. Also op_code=7 -> done at T+1, no mem/rf/pc activity.
